// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with multi-word line refill from memory.
// Hits complete in the request cycle; misses stream a full line in word order.
module icache_refill #(
  parameter int LINES          = 256,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       data,
  output logic              valid,
  input  logic              flush,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINES - 1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    INVAL,
    RUN,
    MREQ,
    FILL
  } state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign word = addr[OFF_W+1:2];
  assign idx  = addr[OFF_W+IDX_W+1:OFF_W+2];
  assign tag  = addr[ADDR_W-1:ADDR_W-TAG_W];

  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  logic [LINES-1:0] vbit_q;
  logic [TAG_W-1:0] tag_arr [LINES];
  logic [31:0]      data_arr [LINES*WORDS_PER_LINE];

  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic             pend_q, pend_d;
  logic [IDX_W-1:0] line_idx_q;
  logic [TAG_W-1:0] line_tag_q;

  logic hit;
  logic miss_go;
  logic fill_we;
  logic line_done;

  assign hit = (state_q == RUN) && req
            && vbit_q[idx] && (tag_arr[idx] == tag);

  // A flush in the same cycle wins over presenting the word.
  assign valid = hit && !flush;
  assign data  = valid ? data_arr[{idx, word}] : 32'h0;

  assign busy     = (state_q != RUN);
  assign mem_req  = (state_q == MREQ);
  assign mem_addr = {line_tag_q, line_idx_q, (OFF_W+2)'(0)};

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    beat_d    = beat_q;
    pend_d    = pend_q;
    miss_go   = 1'b0;
    fill_we   = 1'b0;
    line_done = 1'b0;
    unique case (state_q)
      INVAL: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) state_d = RUN;
      end
      RUN: begin
        if (flush) begin
          sweep_d = '0;
          state_d = INVAL;
        end else if (req && !hit) begin
          miss_go = 1'b1;
          state_d = MREQ;
        end
      end
      MREQ: begin
        if (flush) pend_d = 1'b1;
        if (mem_gnt) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (flush) pend_d = 1'b1;
        if (mem_rvalid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            line_done = 1'b1;
            pend_d    = 1'b0;
            sweep_d   = '0;
            state_d   = (pend_q || flush) ? INVAL : RUN;
          end
        end
      end
      default: state_d = INVAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INVAL;
      sweep_q    <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      line_idx_q <= '0;
      line_tag_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      beat_q  <= beat_d;
      pend_q  <= pend_d;
      if (miss_go) begin
        line_idx_q <= idx;
        line_tag_q <= tag;
      end
    end
  end

  // Valid bit drops at miss start so a partly filled line never hits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INVAL)
        vbit_q[sweep_q] <= 1'b0;
      else if (miss_go)
        vbit_q[idx] <= 1'b0;
      else if (line_done)
        vbit_q[line_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_we)
      data_arr[{line_idx_q, beat_q}] <= mem_rdata;
    if (!rst && line_done)
      tag_arr[line_idx_q] <= line_tag_q;
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: sweep timing, refills, conflicts,
// gapped beats, flush and reset during refill.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data;
  logic        valid;
  logic        flush = 1'b0;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errs = 0;
  int checks = 0;

  icache_refill #(
    .LINES(256), .WORDS_PER_LINE(4), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr),
    .data(data), .valid(valid), .flush(flush), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        r;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vecs(input string nm);
    foreach (vq[i]) begin
      req  = vq[i].r;
      addr = vq[i].a;
      @(negedge clk);
      chk($sformatf("%s[%0d].valid", nm, i), {31'b0, valid}, {31'b0, vq[i].ev});
      chk($sformatf("%s[%0d].data", nm, i), data, vq[i].ed);
      chk($sformatf("%s[%0d].mem_req", nm, i), {31'b0, mem_req}, 0);
      req = 1'b0;
      cyc();
    end
    vq.delete();
  endtask

  task automatic count_busy(input string nm, input int exp);
    int n;
    bit bad;
    n = 0;
    bad = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!busy) break;
      if (valid !== 1'b0 || mem_req !== 1'b0) bad = 1;
      n++;
      cyc();
    end
    chk({nm, "_cycles"}, n, exp);
    chk({nm, "_quiet"}, {31'b0, bad}, 0);
    cyc();
  endtask

  task automatic refill(input string nm, input logic [31:0] a,
                        input int gw, input logic [31:0] base,
                        input int gap);
    logic [31:0] la;
    bit bad_req, bad_beat;
    la = a & 32'hFFFF_FFF0;
    bad_req = 0;
    bad_beat = 0;
    req  = 1'b1;
    addr = a;
    @(negedge clk);
    chk({nm, "_miss_valid"}, {31'b0, valid}, 0);
    cyc();
    for (int i = 0; i < gw; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_addr !== la) bad_req = 1;
      cyc();
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk({nm, "_mem_req"}, {31'b0, mem_req}, 1);
    chk({nm, "_mem_addr"}, mem_addr, la);
    cyc();
    mem_gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        if (valid !== 1'b0 || mem_req !== 1'b0) bad_beat = 1;
        cyc();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = base + b;
      @(negedge clk);
      if (valid !== 1'b0 || mem_req !== 1'b0) bad_beat = 1;
      cyc();
      mem_rvalid = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_fill_valid"}, {31'b0, valid}, 1);
    chk({nm, "_fill_data"}, data, base + a[3:2]);
    chk({nm, "_req_wait"}, {31'b0, bad_req}, 0);
    chk({nm, "_beat_wait"}, {31'b0, bad_beat}, 0);
    req = 1'b0;
    cyc();
  endtask

  initial begin
    // Reset and the power-up sweep.
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 1);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_data", data, 0);
    cyc();
    rst = 1'b0;
    count_busy("sweep", 256);

    // Cold miss, two-cycle grant wait, back-to-back beats.
    refill("cold", 32'h100, 2, 32'hA0, 1);
    vq.push_back('{32'h10C, 1'b1, 1'b1, 32'hA3});
    vq.push_back('{32'h104, 1'b1, 1'b1, 32'hA1});
    vq.push_back('{32'h108, 1'b1, 1'b1, 32'hA2});
    vq.push_back('{32'h100, 1'b0, 1'b0, 32'h0});
    vq.push_back('{32'h1100, 1'b1, 1'b0, 32'h0});
    vq.push_back('{32'h200, 1'b1, 1'b0, 32'h0});
    apply_vecs("hit1");

    // Conflict on index 0x10, then 0x100 is evicted.
    refill("conf", 32'h1100, 0, 32'hB0, 1);
    vq.push_back('{32'h110C, 1'b1, 1'b1, 32'hB3});
    vq.push_back('{32'h1104, 1'b1, 1'b1, 32'hB1});
    vq.push_back('{32'h100, 1'b1, 1'b0, 32'h0});
    apply_vecs("hit2");

    // Gapped beats, every third cycle.
    refill("gap", 32'h108, 1, 32'hC0, 3);
    vq.push_back('{32'h100, 1'b1, 1'b1, 32'hC0});
    vq.push_back('{32'h104, 1'b1, 1'b1, 32'hC1});
    vq.push_back('{32'h10C, 1'b1, 1'b1, 32'hC3});
    vq.push_back('{32'h1100, 1'b1, 1'b0, 32'h0});
    apply_vecs("hit3");

    // Flush pulse during FILL after beat 1.
    req  = 1'b1;
    addr = 32'h300;
    cyc();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0 + b;
      cyc();
    end
    mem_rvalid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    for (int b = 2; b < 4; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0 + b;
      cyc();
    end
    mem_rvalid = 1'b0;
    req = 1'b0;
    count_busy("flush_sweep", 256);
    vq.push_back('{32'h100, 1'b1, 1'b0, 32'h0});
    vq.push_back('{32'h300, 1'b1, 1'b0, 32'h0});
    apply_vecs("post_flush");

    // Reset while in FILL after beat 2.
    req  = 1'b1;
    addr = 32'h100;
    cyc();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hF0 + b;
      cyc();
    end
    rst = 1'b1;
    mem_rdata = 32'hF3;
    cyc();
    rst = 1'b0;
    req = 1'b0;
    mem_rdata = 32'hF4;
    @(negedge clk);
    chk("rst_fill_mem_req", {31'b0, mem_req}, 0);
    chk("rst_fill_busy", {31'b0, busy}, 1);
    cyc();
    mem_rvalid = 1'b0;
    // One sweep cycle is already consumed above.
    count_busy("rst_fill_sweep", 255);
    refill("after_rst", 32'h100, 1, 32'hD0, 1);
    vq.push_back('{32'h104, 1'b1, 1'b1, 32'hD1});
    vq.push_back('{32'h108, 1'b1, 1'b1, 32'hD2});
    vq.push_back('{32'h10C, 1'b1, 1'b1, 32'hD3});
    vq.push_back('{32'h300, 1'b1, 1'b0, 32'h0});
    apply_vecs("hit4");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Parametrised direct-mapped, multi-word-line instruction cache between fetch and a main-memory read port.
- Fetch hits complete in the request cycle.
- Misses run a line refill from memory over a request/grant plus in-order data-beat handshake.
- Supports per-line valid bits, a hardware invalidate sweep after reset, and a flush (fence.i) request.

Parameters:
- LINES, 256, number of cache lines; power of 2, >= 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, >= 2.
- ADDR_W, 32, address width.
- Derived: OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(LINES), TAG_W = ADDR_W - IDX_W - OFF_W - 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  fetch read request.
- addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- data  out  32  instruction word; 0 when valid=0.
- valid  out  1  data valid for the current req/addr (hit).
- flush  in  1  single-cycle pulse: invalidate all lines.
- busy  out  1  cache in INVAL, MREQ or FILL.
- mem_req  out  1  line read request to memory.
- mem_addr  out  ADDR_W  line-aligned refill address; low OFF_W+2 bits are 0.
- mem_gnt  in  1  memory accepts request (sampled while mem_req=1).
- mem_rvalid  in  1  refill data beat valid.
- mem_rdata  in  32  refill data beat.

Behaviour:
- Address split:
  - word = addr[OFF_W+1:2]
  - index = addr[OFF_W+IDX_W+1:OFF_W+2]
  - tag = upper TAG_W bits.
- Storage: tag array, valid-bit array, data array of LINES*WORDS_PER_LINE words.
- hit = (state==RUN) & req & valid_bit[index] & (tag_arr[index]==tag). valid=hit and data=word on hit, combinationally in the same cycle (0-cycle hit latency).
- States: INVAL, RUN, MREQ, FILL.
- Reset:
  - state=INVAL, sweep counter=0.
  - mem_req=0, valid=0, data=0, busy=1.
  - Pending-flush flag cleared.
- INVAL:
  - Clears one valid bit per cycle, index 0 to LINES-1; exactly LINES cycles; valid=0 throughout.
  - Goes to RUN after clearing index LINES-1.
- RUN:
  - req & miss: latch the line address, go to MREQ. Fetch must hold req/addr stable until valid=1; behaviour is undefined if addr changes during a miss.
  - flush (no miss in progress): go to INVAL, takes priority over a same-cycle miss; valid=0 that cycle.
- MREQ:
  - mem_req=1, mem_addr=latched line address, held until mem_gnt=1.
  - On grant: mem_req drops next cycle, beat counter=0, go to FILL.
- FILL:
  - Each mem_rvalid writes mem_rdata to data[index][beat], increments beat counter. Beats arrive in word order 0..WORDS_PER_LINE-1; gaps allowed.
  - On the last beat, in the same edge: write tag, set valid bit, go to RUN.
  - The next cycle hits: miss penalty = 1 (MREQ) + grant wait + beat cycles + 1.
  - The line's valid bit is cleared at MREQ entry, so a partial line is never hit.
- Flush in MREQ/FILL: set the pending flag; the refill completes normally, then go to INVAL instead of RUN. The returned word is not presented.
- mem_rvalid outside FILL and mem_gnt outside MREQ are ignored.
- Reset mid-refill: state to INVAL immediately. mem_req drops the cycle after rst. Remaining beats of the aborted burst are ignored. Memory must tolerate request abort.
- req=0: no state change in RUN; valid=0.
- Conflict miss overwrites the resident line (no replacement choice).

Test Plan:
- Reset, then idle: busy=1 for exactly 256 cycles, valid=0, mem_req=0; busy=0 on cycle 257.
- Cold miss req addr=0x0000_0100, gnt after 2 cycles, beats 0xA0..0xA3 back-to-back:
  - mem_addr=0x100 while mem_req=1.
  - Cycle after last beat: valid=1, data=0xA0.
  - Then addr=0x10C hits with data=0xA3 same cycle, no mem_req.
- Conflict: after filling 0x100, req 0x1100 (same index 0x10, tag 1):
  - Miss, mem_addr=0x1100.
  - After fill, 0x1100 hits; 0x100 then misses again.
- Gapped beats: mem_rvalid asserted every 3rd cycle. valid stays 0 until the 4th beat is written; data matches per word.
- Flush during FILL (after beat 1): refill completes, then INVAL 256 cycles (busy=1). Subsequent req 0x100 misses.
- Reset asserted in FILL after beat 2: next cycle state INVAL, mem_req=0. Further beats ignored. After sweep, req 0x100 misses and refills correctly.
